// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage constants and the buffered {pc, instr} entry type
package fetch_pkg;
  localparam int WORD_BITWIDTH = 32;
  localparam logic [WORD_BITWIDTH-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [WORD_BITWIDTH-1:0] PC_STEP = 32'd4;
  localparam logic [WORD_BITWIDTH-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [WORD_BITWIDTH-1:0] pc;
    logic [WORD_BITWIDTH-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO (push/pop/flush, count/full/empty), flush beats push and pop
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing imem requests, buffering {pc, instr} for decode, dropping wrong-path responses on redirect
module instruction_fetch #(
  parameter int WORD_BITWIDTH = fetch_pkg::WORD_BITWIDTH,
  parameter logic [WORD_BITWIDTH-1:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [WORD_BITWIDTH-1:0] imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [WORD_BITWIDTH-1:0] imem_resp_data,
  input  logic                     redirect_valid,
  input  logic [WORD_BITWIDTH-1:0] redirect_pc,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [WORD_BITWIDTH-1:0] if_pc,
  output logic [WORD_BITWIDTH-1:0] if_instruction
);
  import fetch_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WORD_BITWIDTH-1:0] STEP = WORD_BITWIDTH'(PC_STEP);
  logic [WORD_BITWIDTH-1:0] pc, resp_pc, target;
  logic [2*WORD_BITWIDTH-1:0] rd_data;
  logic [CW-1:0] outstanding, drop_cnt, count, remaining;
  logic full, empty, req_fire, push, pop;
  assign target = redirect_pc & ~WORD_BITWIDTH'(3);
  assign imem_req_valid = !rst && !redirect_valid && ({1'b0, outstanding} + {1'b0, count} < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr = pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign push = imem_resp_valid && !redirect_valid && drop_cnt == '0;
  assign pop = if_valid && if_ready;
  assign if_valid = !empty;
  assign {if_pc, if_instruction} = rd_data;
  assign remaining = outstanding - CW'(imem_resp_valid);
  fetch_fifo #(.WIDTH(2*WORD_BITWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .wr_data({resp_pc, imem_resp_data}),
    .rd_data(rd_data),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk)
    if (rst) begin
      pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc <= target;
      resp_pc <= target;
      outstanding <= remaining;
      drop_cnt <= remaining;
    end else begin
      pc <= req_fire ? pc + STEP : pc;
      resp_pc <= push ? resp_pc + STEP : resp_pc;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      drop_cnt <= (imem_resp_valid && drop_cnt != '0) ? drop_cnt - CW'(1) : drop_cnt;
    end
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed self-checking bench with a fixed-latency imem model (instr = ~addr)
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req_valid;
  logic imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic if_valid;
  logic if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  int checks = 0;
  int errors = 0;
  int lat = 1;
  logic [7:0] pv;
  logic [31:0] pa [8];

  instruction_fetch dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_pc(if_pc),
    .if_instruction(if_instruction)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst) pv <= '0;
    else begin
      pv <= {pv[6:0], imem_req_valid && imem_req_ready};
      for (int i = 7; i > 0; i--) pa[i] <= pa[i-1];
      pa[0] <= imem_req_addr;
    end

  assign imem_resp_valid = pv[lat-1];
  assign imem_resp_data = ~pa[lat-1];

  task automatic do_reset(input int l);
    rst = 1'b1;
    lat = l;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lat = 1;
    if_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h expected 0", if_pc); end
    checks++; if (if_instruction !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h expected 0", if_instruction); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h expected 0", imem_req_addr); end
  endtask

  task automatic test_stream();
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      checks++; if (imem_req_addr !== 32'(4*(c-1))) begin errors++; $display("FAIL stream_addr c%0d: got %h expected %h", c, imem_req_addr, 32'(4*(c-1))); end
      if (c == 2) begin
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid: got %b expected 0", if_valid); end
      end else begin
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4*(c-3)) || if_instruction !== ~32'(4*(c-3)))
          begin errors++; $display("FAIL stream_out c%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", c, if_valid, if_pc, if_instruction, 32'(4*(c-3)), ~32'(4*(c-3))); end
      end
    end
  endtask

  task automatic test_stall();
    int got;
    logic [31:0] exp;
    if_ready = 1'b0;
    do_reset(1);
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instruction !== 32'hFFFF_FFFF)
          begin errors++; $display("FAIL stall_hold c%0d: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=ffffffff", c, if_valid, if_pc, if_instruction); end
      end
    end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL stall_count: got %0d expected 4", dut.count); end
    if_ready = 1'b1;
    got = 0;
    exp = 32'h0;
    for (int i = 0; i < 40 && got < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (if_valid) begin
        checks++; if (if_pc !== exp || if_instruction !== ~exp) begin errors++; $display("FAIL drain_order: got pc=%h instr=%h expected pc=%h instr=%h", if_pc, if_instruction, exp, ~exp); end
        exp += 32'd4;
        got++;
      end
    end
    checks++; if (got != 12) begin errors++; $display("FAIL drain_count: got %0d expected 12", got); end
  endtask

  task automatic first_valid(input string name, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (!if_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instruction !== ~exp_pc)
      begin errors++; $display("FAIL %s: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", name, if_valid, if_pc, if_instruction, exp_pc, ~exp_pc); end
  endtask

  task automatic test_redirect_stale();
    if_ready = 1'b1;
    do_reset(3);
    repeat (2) @(negedge clk);
    checks++; if (dut.outstanding !== 3'd2) begin errors++; $display("FAIL stale_outstanding: got %0d expected 2", dut.outstanding); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    imem_req_ready = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stale_req_in_redirect: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    checks++; if (dut.drop_cnt !== 3'd2) begin errors++; $display("FAIL stale_drop_cnt: got %0d expected 2", dut.drop_cnt); end
    checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL stale_addr: got %h expected 100", imem_req_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stale_flush: got %b expected 0", if_valid); end
    first_valid("stale_first_pc", 32'h100);
  endtask

  task automatic test_redirect_pop();
    if_ready = 1'b1;
    do_reset(2);
    repeat (3) @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_resp_valid !== 1'b1 || dut.outstanding !== 3'd2)
      begin errors++; $display("FAIL pop_setup: got v=%b pc=%h resp=%b out=%0d expected v=1 pc=0 resp=1 out=2", if_valid, if_pc, imem_resp_valid, dut.outstanding); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL pop_flush: got %b expected 0", if_valid); end
    checks++; if (dut.drop_cnt !== 3'd1) begin errors++; $display("FAIL pop_drop_cnt: got %0d expected 1", dut.drop_cnt); end
    checks++; if (dut.outstanding !== 3'd1) begin errors++; $display("FAIL pop_outstanding: got %0d expected 1", dut.outstanding); end
    first_valid("pop_first_pc", 32'h40);
  endtask

  task automatic test_double_redirect();
    logic saw;
    logic first;
    if_ready = 1'b1;
    do_reset(2);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_pc = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    saw = 1'b0;
    first = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (if_valid) begin
        if (if_pc[31:8] == 24'h2) saw = 1'b1;
        if (first) begin
          checks++; if (if_pc !== 32'h300 || if_instruction !== ~32'h300) begin errors++; $display("FAIL double_first_pc: got pc=%h instr=%h expected pc=300 instr=%h", if_pc, if_instruction, ~32'h300); end
          first = 1'b0;
        end
      end
      @(negedge clk);
    end
    checks++; if (first) begin errors++; $display("FAIL double_no_output: got none expected pc=300"); end
    checks++; if (saw) begin errors++; $display("FAIL double_leak_0x200: got 0x200-path entry expected none"); end
  endtask

  task automatic test_unaligned();
    logic [31:0] exp_addr, exp_pc, a;
    logic stall, fire;
    int got;
    if_ready = 1'b1;
    do_reset(1);
    imem_req_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL unaligned_addr: got %h expected 100", imem_req_addr); end
    exp_addr = 32'h100;
    exp_pc = 32'h100;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      #1;
      stall = imem_req_valid && !imem_req_ready;
      fire = imem_req_valid && imem_req_ready;
      a = imem_req_addr;
      @(negedge clk);
      if (stall) begin
        checks++; if (imem_req_addr !== a) begin errors++; $display("FAIL unaligned_hold: got %h expected %h", imem_req_addr, a); end
      end
      if (fire) exp_addr += 32'd4;
      checks++; if (imem_req_addr !== exp_addr) begin errors++; $display("FAIL unaligned_track: got %h expected %h", imem_req_addr, exp_addr); end
      if (if_valid) begin
        checks++; if (if_pc !== exp_pc || if_instruction !== ~exp_pc) begin errors++; $display("FAIL unaligned_out: got pc=%h instr=%h expected pc=%h instr=%h", if_pc, if_instruction, exp_pc, ~exp_pc); end
        exp_pc += 32'd4;
        got++;
      end
    end
    checks++; if (got < 5) begin errors++; $display("FAIL unaligned_progress: got %0d entries expected at least 5", got); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_redirect_pop();
    test_double_redirect();
    test_unaligned();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish within 200000");
    $fatal(1);
  end
endmodule
